encode_sched: RTL and testbench

ENCODE_SCHED -- requirements
Module: encode_sched

---
 rtl/encode_sched.sv | 166 ++++++++++++++++
 tb/tb_encode_sched.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encode_sched.sv
// Round-robin scheduler sharing one fixed-latency encoder among N_REQ requesters;
// results come back tagged with the requester id, in issue order, via a response FIFO.
module encode_sched #(
    parameter  int N_REQ      = 4,
    parameter  int DATA_W     = 16,
    parameter  int ENC_W      = 21,
    parameter  int ENC_LAT    = 1,
    parameter  int FIFO_DEPTH = 4,
    localparam int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]       enc_raw_data,
    output logic                    enc_valid_in,
    input  logic [ENC_W-1:0]        enc_encoded_data,
    input  logic                    enc_valid_out,
    output logic                    resp_valid,
    output logic [ENC_W-1:0]        resp_data,
    output logic [ID_W-1:0]         resp_id,
    input  logic                    resp_ready,
    output logic                    err,
    output logic                    busy
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;
    localparam int ICNT_W = $clog2(ENC_LAT + 1);
    localparam int CRED_W = $clog2(FIFO_DEPTH + ENC_LAT + 1) + 1;
    localparam int BLK_W  = $clog2(ENC_LAT + 1);

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_id;
    logic              grant_found;
    logic              credit_ok;
    logic              issue;
    logic [ENC_LAT-1:0] tag_valid;
    logic [ID_W-1:0]   tag_id [ENC_LAT];
    logic [ICNT_W-1:0] inflight_count;
    logic [FCNT_W-1:0] fifo_count;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [ENC_W-1:0]  mem_data [FIFO_DEPTH];
    logic [ID_W-1:0]   mem_id [FIFO_DEPTH];
    logic [BLK_W-1:0]  blank_cnt;
    logic              blanking;
    logic              last_valid;
    logic              push;
    logic              pop;
    logic              err_q;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        logic [ID_W:0] idx;
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            if (idx >= (ID_W + 1)'(N_REQ)) begin
                idx = idx - (ID_W + 1)'(N_REQ);
            end
            if (!grant_found && req_valid[idx[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        inflight_count = '0;
        for (int k = 0; k < ENC_LAT; k++) begin
            inflight_count = inflight_count + ICNT_W'(tag_valid[k]);
        end
    end

    // Results already in the encoder hold a FIFO slot, so a push can never hit a full FIFO.
    assign credit_ok    = (CRED_W'(fifo_count) + CRED_W'(inflight_count)) < CRED_W'(FIFO_DEPTH);
    assign issue        = grant_found & ~rst & credit_ok;
    assign enc_valid_in = issue;
    assign enc_raw_data = issue ? req_data[int'(grant_id) * DATA_W +: DATA_W] : '0;

    always_comb begin
        req_ready = '0;
        if (issue) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (issue) begin
            rr_ptr <= (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid <= '0;
            for (int k = 0; k < ENC_LAT; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            tag_valid[0] <= issue;
            tag_id[0]    <= grant_id;
            for (int k = 1; k < ENC_LAT; k++) begin
                tag_valid[k] <= tag_valid[k-1];
                tag_id[k]    <= tag_id[k-1];
            end
        end
    end

    assign last_valid = tag_valid[ENC_LAT-1];
    assign blanking   = (blank_cnt != '0);
    assign push       = last_valid & ~blanking;
    assign pop        = resp_valid & resp_ready;

    // Encoder output is untrusted for ENC_LAT cycles after reset while its pipeline flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            blank_cnt <= BLK_W'(ENC_LAT);
            err_q     <= 1'b0;
        end else if (blanking) begin
            blank_cnt <= blank_cnt - BLK_W'(1);
        end else if (enc_valid_out != last_valid) begin
            err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= enc_encoded_data;
            mem_id[wr_ptr]   <= tag_id[ENC_LAT-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
                2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign resp_valid = ~rst & (fifo_count != '0);
    assign resp_data  = mem_data[rd_ptr];
    assign resp_id    = mem_id[rd_ptr];
    assign busy       = ~rst & ((inflight_count != '0) | (fifo_count != '0));
    assign err        = err_q & ~rst;

endmodule

// File: tb/tb_encode_sched.sv
// Bench for encode_sched: behavioural Hamming(21,16) encoder with ENC_LAT latency
// and a scoreboard of expected {id, encoded} responses in issue order.
module tb_encode_sched;

    localparam int N_REQ      = 4;
    localparam int DATA_W     = 16;
    localparam int ENC_W      = 21;
    localparam int ENC_LAT    = 1;
    localparam int FIFO_DEPTH = 4;
    localparam int ID_W       = 2;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [N_REQ-1:0]        req_valid = '0;
    logic [N_REQ*DATA_W-1:0] req_data = '0;
    logic [N_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]       enc_raw_data;
    logic                    enc_valid_in;
    logic [ENC_W-1:0]        enc_encoded_data;
    logic                    enc_valid_out;
    logic                    resp_valid;
    logic [ENC_W-1:0]        resp_data;
    logic [ID_W-1:0]         resp_id;
    logic                    resp_ready = 1'b1;
    logic                    err;
    logic                    busy;

    logic                    inject = 1'b0;
    logic [ENC_LAT-1:0]      model_valid;
    logic [ENC_W-1:0]        model_data [ENC_LAT];

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [ID_W+ENC_W-1:0] exp_q[$];
    logic [ID_W+ENC_W-1:0] got_q[$];
    int grant_q[$];
    int issue_cyc_q[$];
    int resp_cyc_q[$];

    encode_sched #(
        .N_REQ(N_REQ), .DATA_W(DATA_W), .ENC_W(ENC_W),
        .ENC_LAT(ENC_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .enc_raw_data(enc_raw_data), .enc_valid_in(enc_valid_in),
        .enc_encoded_data(enc_encoded_data), .enc_valid_out(enc_valid_out),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_id(resp_id),
        .resp_ready(resp_ready), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Even-parity Hamming code: parity at power-of-two positions, encoded bit i is position i+1.
    function automatic logic [ENC_W-1:0] hamming(input logic [DATA_W-1:0] d);
        logic [ENC_W:1] c;
        int j;
        c = '0;
        j = 0;
        for (int p = 1; p <= ENC_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p] = d[j];
                j++;
            end
        end
        for (int b = 0; (1 << b) <= ENC_W; b++) begin
            logic par;
            par = 1'b0;
            for (int p = 1; p <= ENC_W; p++) begin
                if (((p >> b) & 1) == 1) par = par ^ c[p];
            end
            c[1 << b] = par;
        end
        return c[ENC_W:1];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            model_valid <= '0;
        end else begin
            model_valid[0] <= enc_valid_in;
            model_data[0]  <= hamming(enc_raw_data);
            for (int k = 1; k < ENC_LAT; k++) begin
                model_valid[k] <= model_valid[k-1];
                model_data[k]  <= model_data[k-1];
            end
        end
    end

    assign enc_valid_out    = model_valid[ENC_LAT-1] | inject;
    assign enc_encoded_data = model_data[ENC_LAT-1];

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_q.push_back({ID_W'(i), hamming(req_data[i*DATA_W +: DATA_W])});
                    grant_q.push_back(i);
                    issue_cyc_q.push_back(cycle);
                end
            end
            if (resp_valid && resp_ready) begin
                got_q.push_back({resp_id, resp_data});
                resp_cyc_q.push_back(cycle);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        exp_q.delete();
        got_q.delete();
        grant_q.delete();
        issue_cyc_q.delete();
        resp_cyc_q.delete();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b1;
        inject     = 1'b0;
        tick();
        tick();
        clear_queues();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 60 && !ok; c++) begin
            tick();
            if (got_q.size() >= n && !busy) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        req_valid  = '1;
        resp_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (req_ready !== '0) begin errors++; $display("[TB] FAIL reset_req_ready got %b want 0000", req_ready); end
        checks++;
        if (enc_valid_in !== 1'b0) begin errors++; $display("[TB] FAIL reset_enc_valid_in got %b want 0", enc_valid_in); end
        checks++;
        if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid got %b want 0", resp_valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", err); end
        req_valid = '0;
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        req_data[0 +: DATA_W] = 16'd10;
        req_valid = 4'b0001;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL single_grant got %b want 0001", req_ready); end
        tick();
        req_valid = '0;
        wait_drain(1, ok);
        checks++;
        if (got_q.size() != 1 || !ok) begin errors++; $display("[TB] FAIL single_count got %0d want 1", got_q.size()); end
        if (got_q.size() >= 1 && issue_cyc_q.size() >= 1) begin
            checks++;
            if (got_q[0][ENC_W-1:0] !== 21'd82) begin errors++; $display("[TB] FAIL single_data got %0d want 82", got_q[0][ENC_W-1:0]); end
            checks++;
            if (got_q[0][ID_W+ENC_W-1:ENC_W] !== 2'd0) begin errors++; $display("[TB] FAIL single_id got %0d want 0", got_q[0][ID_W+ENC_W-1:ENC_W]); end
            checks++;
            if (resp_cyc_q[0] - issue_cyc_q[0] != ENC_LAT + 1) begin
                errors++; $display("[TB] FAIL single_latency got %0d want %0d", resp_cyc_q[0] - issue_cyc_q[0], ENC_LAT + 1);
            end
        end
    endtask

    task automatic test_all_four();
        int unsigned lit[4] = '{82, 599040, 1433996, 82};
        logic [N_REQ-1:0] seen;
        bit ok;
        do_reset();
        req_data  = {16'd10, 16'd44561, 16'd19008, 16'd10};
        req_valid = '1;
        for (int c = 0; c < 20 && req_valid != '0; c++) begin
            @(negedge clk);
            seen = req_ready;
            tick();
            req_valid = req_valid & ~seen;
        end
        req_valid = '0;
        wait_drain(4, ok);
        checks++;
        if (got_q.size() != 4 || grant_q.size() != 4 || !ok) begin
            errors++; $display("[TB] FAIL all4_count got %0d grants %0d responses want 4", grant_q.size(), got_q.size());
        end
        for (int i = 0; i < 4 && i < grant_q.size(); i++) begin
            checks++;
            if (grant_q[i] != i) begin errors++; $display("[TB] FAIL all4_grant[%0d] got %0d want %0d", i, grant_q[i], i); end
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i][ENC_W-1:0] !== ENC_W'(lit[i])) begin errors++; $display("[TB] FAIL all4_data[%0d] got %0d want %0d", i, got_q[i][ENC_W-1:0], lit[i]); end
            checks++;
            if (got_q[i][ID_W+ENC_W-1:ENC_W] !== ID_W'(i)) begin errors++; $display("[TB] FAIL all4_id[%0d] got %0d want %0d", i, got_q[i][ID_W+ENC_W-1:ENC_W], i); end
        end
    endtask

    task automatic test_backpressure();
        int accepted;
        logic [DATA_W-1:0] d;
        bit ok;
        do_reset();
        resp_ready = 1'b0;
        d = 16'h0100;
        req_data[2*DATA_W +: DATA_W] = d;
        req_valid = 4'b0100;
        accepted = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req_ready[2]) begin accepted++; d = d + 16'd37; end
            tick();
            req_data[2*DATA_W +: DATA_W] = d;
        end
        @(negedge clk);
        checks++;
        if (accepted != FIFO_DEPTH) begin errors++; $display("[TB] FAIL bp_accepted got %0d want %0d", accepted, FIFO_DEPTH); end
        checks++;
        if (req_ready !== '0) begin errors++; $display("[TB] FAIL bp_stalled got %b want 0000", req_ready); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL bp_busy got %b want 1", busy); end
        if (exp_q.size() >= 1) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== exp_q[0][ENC_W-1:0]) begin
                errors++; $display("[TB] FAIL bp_head_held got v=%b %0h want v=1 %0h", resp_valid, resp_data, exp_q[0][ENC_W-1:0]);
            end
        end
        resp_ready = 1'b1;
        for (int c = 0; c < 40 && accepted < 10; c++) begin
            tick();
            req_data[2*DATA_W +: DATA_W] = d;
            @(negedge clk);
            if (req_ready[2]) begin accepted++; d = d + 16'd37; end
        end
        tick();
        req_valid = '0;
        wait_drain(10, ok);
        checks++;
        if (!ok || got_q.size() != 10 || exp_q.size() != 10) begin
            errors++; $display("[TB] FAIL bp_count got %0d responses %0d issues want 10", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL bp_resp[%0d] got %0h want %0h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_round_robin();
        int want;
        int base;
        int served_at;
        bit ok;
        do_reset();
        req_valid = 4'b1010;
        for (int c = 0; c < 6; c++) begin
            req_data = {$urandom, $urandom};
            tick();
        end
        checks++;
        if (grant_q.size() != 6) begin errors++; $display("[TB] FAIL rr_throughput got %0d want 6", grant_q.size()); end
        for (int i = 0; i < 6 && i < grant_q.size(); i++) begin
            want = (i % 2 == 0) ? 1 : 3;
            checks++;
            if (grant_q[i] != want) begin errors++; $display("[TB] FAIL rr_grant[%0d] got %0d want %0d", i, grant_q[i], want); end
        end
        base = grant_q.size();
        req_valid = 4'b1011;
        for (int c = 0; c < N_REQ + 2; c++) begin
            req_data = {$urandom, $urandom};
            tick();
        end
        req_valid = '0;
        served_at = -1;
        for (int i = base; i < grant_q.size(); i++) begin
            if (grant_q[i] == 0 && served_at < 0) served_at = i - base;
        end
        checks++;
        if (served_at < 0 || served_at >= N_REQ) begin errors++; $display("[TB] FAIL rr_req0_served got %0d want 0..%0d", served_at, N_REQ - 1); end
        wait_drain(grant_q.size(), ok);
        checks++;
        if (!ok || got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL rr_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL rr_resp[%0d] got %0h want %0h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_err();
        do_reset();
        inject = 1'b1;
        tick();
        inject = 1'b0;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL err_blanking got %b want 0", err); end
        checks++;
        if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL blank_no_push got %b want 0", resp_valid); end
        tick();
        inject = 1'b1;
        tick();
        inject = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_set got %b want 1", err); end
        repeat (5) tick();
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky got %b want 1", err); end
        rst = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL err_reset got %b want 0", err); end
    endtask

    task automatic test_reset_mid();
        int accepted;
        logic [DATA_W-1:0] d;
        logic [ID_W+ENC_W-1:0] want;
        bit ok;
        do_reset();
        resp_ready = 1'b0;
        d = 16'h2222;
        req_data[DATA_W +: DATA_W] = d;
        req_valid = 4'b0010;
        accepted = 0;
        for (int c = 0; c < 20 && accepted < 4; c++) begin
            @(negedge clk);
            if (req_ready[1]) begin accepted++; d = d + 16'd5; end
            tick();
            req_data[DATA_W +: DATA_W] = d;
        end
        req_valid = '0;
        checks++;
        if (busy !== 1'b1 || resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_preload got busy=%b v=%b want 1 1", busy, resp_valid); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_outputs got v=%b busy=%b want 0 0", resp_valid, busy); end
        tick();
        clear_queues();
        rst = 1'b0;
        req_data[DATA_W*3 +: DATA_W] = 16'h0777;
        req_valid = 4'b1010;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_flushed got v=%b busy=%b want 0 0", resp_valid, busy); end
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL mid_rr_restart got %b want 0010", req_ready); end
        want = {2'd1, hamming(d)};
        tick();
        req_valid  = '0;
        resp_ready = 1'b1;
        wait_drain(1, ok);
        checks++;
        if (!ok || got_q.size() != 1) begin errors++; $display("[TB] FAIL mid_resp_count got %0d want 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            checks++;
            if (got_q[0] !== want) begin errors++; $display("[TB] FAIL mid_resp got %0h want %0h", got_q[0], want); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_backpressure();
        test_round_robin();
        test_err();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
